// File: rtl/mem_arb_pkg.sv
`timescale 1ns/1ps
// Shared types and widths for the 64-bit memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_AW    = 32;
  localparam int unsigned MEM_DW    = 64;
  localparam int unsigned MAX_PORTS = 8;
  localparam int unsigned TPORT_W   = 3;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Command payload presented to the memory controller.
  typedef struct packed {
    logic [MEM_AW-1:0] address;
    logic              wren;
    logic [MEM_DW-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter64_rr_picker.sv
`timescale 1ns/1ps
// Cyclic priority encoder: first set bit of req at or after rr_ptr.
module rr_picker #(
  parameter int unsigned NUM_PORTS = 2,
  localparam int unsigned IDX_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 any,
  output logic [IDX_W-1:0]     idx
);

  // Candidate index rr_ptr+k wrapped into 0..NUM_PORTS-1.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned       k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return IDX_W'(s);
  endfunction

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    any = |req;
    idx = '0;
    for (int unsigned k = NUM_PORTS; k > 0; k--) begin
      if (req[wrap_idx(rr_ptr, k - 1)]) idx = wrap_idx(rr_ptr, k - 1);
    end
  end

endmodule

// File: rtl/mem_arbiter64.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one 64-bit memory port, one transaction in flight,
// with a watchdog that aborts transactions memory never acknowledges.
module mem_arbiter64
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS-1:0]        port_wren,
  input  logic [NUM_PORTS*MEM_AW-1:0] port_address,
  input  logic [NUM_PORTS*MEM_DW-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]        port_ready,
  output logic [MEM_DW-1:0]           port_rdata,
  output logic [MEM_AW-1:0]           mem_address,
  output logic [MEM_DW-1:0]           to_mem,
  output logic                        mem_req,
  output logic                        mem_wren,
  input  logic [MEM_DW-1:0]           from_mem,
  input  logic                        mem_ready,
  input  logic                        clear_err,
  output logic                        timeout_flag,
  output logic [TPORT_W-1:0]          timeout_port
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);
  localparam int unsigned WD_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   grant, grant_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [WD_W-1:0]    wd_cnt, wd_cnt_nxt;
  logic               flag_nxt;
  logic [TPORT_W-1:0] tport_nxt;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_after_grant;
  logic               wd_expire;
  mem_cmd_t           sel_cmd;

  rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req    (port_req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  assign ptr_after_grant = (grant == LAST_IDX) ? '0 : grant + 1'b1;
  assign wd_expire       = WD_EN && (wd_cnt == WD_LAST);

  // State and bookkeeping registers; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ARB_IDLE;
      grant        <= '0;
      rr_ptr       <= '0;
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
      timeout_port <= '0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      rr_ptr       <= rr_ptr_nxt;
      wd_cnt       <= wd_cnt_nxt;
      timeout_flag <= flag_nxt;
      timeout_port <= tport_nxt;
    end
  end

  // Next-state: grant in IDLE, complete or abort in BUSY; abort beats clear_err.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    wd_cnt_nxt = wd_cnt;
    flag_nxt   = clear_err ? 1'b0 : timeout_flag;
    tport_nxt  = timeout_port;
    case (state)
      ARB_IDLE: begin
        wd_cnt_nxt = '0;
        if (pick_any) begin
          grant_nxt = pick_idx;
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (mem_ready) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = ptr_after_grant;
          wd_cnt_nxt = '0;
        end else if (wd_expire) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = ptr_after_grant;
          wd_cnt_nxt = '0;
          flag_nxt   = 1'b1;
          tport_nxt  = TPORT_W'(grant);
        end else begin
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Payload mux of the granted port.
  always_comb begin
    sel_cmd = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant == IDX_W'(i)) begin
        sel_cmd.address = port_address[i*MEM_AW +: MEM_AW];
        sel_cmd.wren    = port_wren[i];
        sel_cmd.wdata   = port_wdata[i*MEM_DW +: MEM_DW];
      end
    end
  end

  // Completion pulse goes only to the granted port, only while BUSY.
  always_comb begin
    port_ready = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      port_ready[i] = (state == ARB_BUSY) && mem_ready && (grant == IDX_W'(i));
    end
  end

  assign mem_req     = (state == ARB_BUSY);
  assign mem_wren    = mem_req & sel_cmd.wren;
  assign mem_address = sel_cmd.address;
  assign to_mem      = sel_cmd.wdata;
  assign port_rdata  = from_mem;

endmodule

// File: tb/tb_mem_arbiter64.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for mem_arbiter64 (3 ports, 8-cycle watchdog).
module tb_mem_arbiter64;
  import mem_arb_pkg::*;

  localparam int unsigned NP    = 3;
  localparam int unsigned TO    = 8;
  localparam int          N_CYC = 2600;

  typedef struct {
    logic [31:0] addr;
    logic        wren;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } txn_t;

  logic              clk, reset;
  logic [NP-1:0]     port_req, port_wren, port_ready;
  logic [NP*32-1:0]  port_address;
  logic [NP*64-1:0]  port_wdata;
  logic [63:0]       port_rdata, to_mem, from_mem;
  logic [31:0]       mem_address;
  logic              mem_req, mem_wren, mem_ready, clear_err, timeout_flag;
  logic [2:0]        timeout_port;

  mem_arbiter64 #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .port_req(port_req), .port_wren(port_wren),
    .port_address(port_address), .port_wdata(port_wdata),
    .port_ready(port_ready), .port_rdata(port_rdata),
    .mem_address(mem_address), .to_mem(to_mem),
    .mem_req(mem_req), .mem_wren(mem_wren),
    .from_mem(from_mem), .mem_ready(mem_ready),
    .clear_err(clear_err),
    .timeout_flag(timeout_flag), .timeout_port(timeout_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  txn_t exp_q [NP][$];
  txn_t dir_q [NP][$];
  logic [63:0] smem    [logic [31:0]];
  logic [63:0] ref_mem [logic [31:0]];

  function automatic logic [63:0] mem_init(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  function automatic logic [63:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: reference model of the round-robin/watchdog rules and scoreboard pops.
  initial begin : monitor
    bit          m_busy;
    int          m_g, m_ptr, m_cnt;
    logic        e_flag, n_flag;
    logic [2:0]  e_tport;
    logic [NP-1:0] oh;
    txn_t        h;
    bit          found;
    m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0; e_flag = 0; e_tport = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_busy = 0; m_ptr = 0; m_cnt = 0; e_flag = 0; e_tport = 0;
        continue;
      end
      chk("timeout_flag", 64'(timeout_flag), 64'(e_flag));
      chk("timeout_port", 64'(timeout_port), 64'(e_tport));
      n_flag = clear_err ? 1'b0 : e_flag;
      if (!m_busy) begin
        chk("mem_req_idle", 64'(mem_req), 64'(0));
        chk("mem_wren_idle", 64'(mem_wren), 64'(0));
        chk("port_ready_idle", 64'(port_ready), 64'(0));
        found = 0;
        for (int k = 0; k < int'(NP); k++) begin
          int p;
          p = (m_ptr + k) % int'(NP);
          if (!found && port_req[p]) begin
            found = 1; m_g = p;
          end
        end
        if (found) begin
          m_busy = 1; m_cnt = 0;
        end
      end else begin
        chk("mem_req_busy", 64'(mem_req), 64'(1));
        if (exp_q[m_g].size() > 0) begin
          h = exp_q[m_g][0];
          chk("mem_address", 64'(mem_address), 64'(h.addr));
          chk("mem_wren", 64'(mem_wren), 64'(h.wren));
          chk("to_mem", to_mem, h.wdata);
        end
        if (mem_ready) begin
          oh = '0; oh[m_g] = 1'b1;
          chk("port_ready", 64'(port_ready), 64'(oh));
          if (exp_q[m_g].size() > 0) begin
            h = exp_q[m_g].pop_front();
            chk("port_rdata", port_rdata, h.rdata);
          end
          m_busy = 0;
          m_ptr = (m_g + 1) % int'(NP);
        end else begin
          chk("port_ready_wait", 64'(port_ready), 64'(0));
          m_cnt++;
          if (m_cnt == int'(TO)) begin
            m_busy = 0;
            n_flag = 1'b1;
            e_tport = 3'(m_g);
            m_ptr = (m_g + 1) % int'(NP);
          end
        end
      end
      e_flag = n_flag;
    end
  end

  // Driver: requesters, memory stub and directed phases.
  initial begin : driver
    logic [NP-1:0] rdy_seen;
    logic [2:0]    rand_mask;
    int issue_pct, fixed_lat, max_lat, never_pct, spur_pct, clr_pct;
    bit stub_active, rst_pending;
    int stub_cnt, stub_lat, rst_hold;
    txn_t t;

    reset = 1'b1; port_req = '0; port_wren = '0; port_address = '0; port_wdata = '0;
    from_mem = '0; mem_ready = 1'b0; clear_err = 1'b0;
    rand_mask = '0; issue_pct = 0; fixed_lat = -1; max_lat = 3;
    never_pct = 0; spur_pct = 0; clr_pct = 0;
    stub_active = 0; stub_cnt = 0; stub_lat = 0; rst_pending = 0; rst_hold = 0;
    smem[32'h0000_1000]    = 64'hDEADBEEF_CAFEF00D;
    ref_mem[32'h0000_1000] = 64'hDEADBEEF_CAFEF00D;

    #2;
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_wren", 64'(mem_wren), 64'(0));
    chk("rst_port_ready", 64'(port_ready), 64'(0));
    chk("rst_timeout_flag", 64'(timeout_flag), 64'(0));
    chk("rst_timeout_port", 64'(timeout_port), 64'(0));
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      if (cyc == 0) begin
        t.addr = 32'h0000_1000; t.wren = 1'b0; t.wdata = 64'h0; t.rdata = 64'h0;
        dir_q[0].push_back(t);
        fixed_lat = 2;
      end
      if (cyc == 30) spur_pct = 50;
      if (cyc == 50) begin
        spur_pct = 0; rand_mask = 3'b011; issue_pct = 100; fixed_lat = -1; max_lat = 3;
      end
      if (cyc == 150) begin
        rand_mask = '0;
        t.addr = 32'h0000_0020; t.wren = 1'b1; t.wdata = 64'h01234567_89ABCDEF;
        dir_q[1].push_back(t);
        t.wren = 1'b0; t.wdata = 64'h0;
        dir_q[1].push_back(t);
      end
      if (cyc == 200) begin rand_mask = 3'b001; never_pct = 100; end
      if (cyc == 260) never_pct = 0;
      if (cyc == 290) begin rand_mask = 3'b011; rst_pending = 1; end
      if (cyc == 340) begin
        rand_mask = 3'b111; issue_pct = 35; max_lat = 7; never_pct = 6; spur_pct = 12; clr_pct = 6;
      end
      if (cyc == N_CYC - 80) begin rand_mask = '0; never_pct = 0; spur_pct = 0; end

      @(negedge clk);
      rdy_seen = port_ready;
      @(posedge clk); #1;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 1'b0;
      end

      for (int i = 0; i < int'(NP); i++) begin
        if (port_req[i]) begin
          if (rdy_seen[i]) port_req[i] = 1'b0;
        end else if (dir_q[i].size() > 0 ||
                     (rand_mask[i] && int'($urandom_range(0, 99)) < issue_pct)) begin
          if (dir_q[i].size() > 0) t = dir_q[i].pop_front();
          else begin
            t.addr  = {8'(i + 1), 16'h0, 5'($urandom_range(0, 31)), 3'b000};
            t.wren  = 1'($urandom_range(0, 1));
            t.wdata = {$urandom, $urandom};
          end
          t.rdata = ref_read(t.addr);
          if (t.wren) ref_mem[t.addr] = t.wdata;
          exp_q[i].push_back(t);
          port_req[i] = 1'b1;
          port_wren[i] = t.wren;
          port_address[i*32 +: 32] = t.addr;
          port_wdata[i*64 +: 64] = t.wdata;
        end
      end

      #1;
      mem_ready = 1'b0;
      clear_err = (cyc == 270) || (int'($urandom_range(0, 99)) < clr_pct);
      if (mem_req) begin
        if (!stub_active) begin
          stub_active = 1; stub_cnt = 0;
          if (fixed_lat >= 0) stub_lat = fixed_lat;
          else if (int'($urandom_range(0, 99)) < never_pct) stub_lat = 1000;
          else stub_lat = int'($urandom_range(0, max_lat));
        end
        if (stub_cnt == stub_lat) begin
          mem_ready = 1'b1;
          from_mem = smem.exists(mem_address) ? smem[mem_address] : mem_init(mem_address);
          if (mem_wren) smem[mem_address] = to_mem;
          stub_active = 0;
        end
        stub_cnt++;
      end else begin
        stub_active = 0;
        from_mem = {$urandom, $urandom};
        if (!reset && int'($urandom_range(0, 99)) < spur_pct) mem_ready = 1'b1;
      end

      if (rst_pending && mem_req && !mem_ready) begin
        #1 reset = 1'b1;
        #1;
        chk("async_rst_mem_req", 64'(mem_req), 64'(0));
        chk("async_rst_port_ready", 64'(port_ready), 64'(0));
        chk("async_rst_mem_wren", 64'(mem_wren), 64'(0));
        chk("async_rst_timeout_flag", 64'(timeout_flag), 64'(0));
        rst_pending = 0; rst_hold = 2; stub_active = 0;
      end
    end

    for (int i = 0; i < int'(NP); i++)
      chk("drained_port", 64'(exp_q[i].size()), 64'(0));
    chk("reset_applied", 64'(rst_pending), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
